sqrt_seq_ctrl: RTL and testbench
================================

Name: sqrt_seq_ctrl

Overview:
Upstream sequencer for the psdsqrt square-root core. It accepts operands over a valid/ready handshake and registers each operand onto the core's xin. It pulses start, waits a fixed number of iteration cycles, pulses stop, then captures the core's sqrt output. It returns the root, the remainder and an error check to the consumer over a second valid/ready handshake, so the rest of the design never sequences the core directly.

Parameters:
NUMBITS, 32, operand width; root width is NUMBITS/2 (must be even, >=4)
ITERS, NUMBITS/2, core iteration cycles between the start pulse and the stop pulse (>=1)

Ports:
clock  input  1  master clock, rising edge
reset  input  1  asynchronous reset, active high
in_valid  input  1  operand available
in_ready  output  1  controller can accept an operand
in_x  input  NUMBITS  operand, unsigned
sq_start  output  1  one-cycle start pulse to the core
sq_stop  output  1  one-cycle stop pulse to the core
sq_xin  output  NUMBITS  registered operand to the core
sq_sqrt  input  NUMBITS/2  root returned by the core
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_sqrt  output  NUMBITS/2  root
out_rem  output  NUMBITS/2+1  in_x minus out_sqrt squared
out_exact  output  1  out_rem == 0 and no error
out_err  output  1  core result inconsistent
busy  output  1  state != IDLE
op_count  output  16  completed transactions, wraps at 0xFFFF -> 0

Behaviour:
- Reset is asynchronous, active high, on clock/reset. While reset is asserted:
  - state = IDLE.
  - All outputs are 0, except in_ready = 1.
  - The operand register, result registers and op_count are cleared.
- States: IDLE, START, RUN, STOP, LOAD, DONE.
- IDLE:
  - in_ready = 1.
  - When in_valid=1 at a clock edge: latch in_x into sq_xin and go to START.
- START (1 cycle): sq_start = 1; load the iteration counter with ITERS-1; go to RUN.
- RUN (ITERS cycles): the counter decrements each cycle; at 0 go to STOP.
- STOP (1 cycle): sq_stop = 1; go to LOAD.
- LOAD (1 cycle):
  - Register sq_sqrt into out_sqrt.
  - Compute sq = sq_sqrt*sq_sqrt at full NUMBITS width.
  - If sq > sq_xin: out_err = 1, out_rem = 0, out_exact = 0.
  - Otherwise: out_err = 0, out_rem = sq_xin - sq, out_exact = (out_rem == 0).
  - If (sq_xin - sq) > 2*sq_sqrt, the root is too small: out_err = 1, out_rem is still reported, out_exact = 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; all out_* are held stable until accepted.
  - On out_valid & out_ready: increment op_count and go to IDLE.
  - The next operand can be accepted no earlier than the cycle after DONE.
- sq_xin stays stable from START through LOAD; sq_start and sq_stop are never high in the same cycle.
- in_ready is 0 in every state except IDLE; in_valid outside IDLE is ignored and not buffered.
- Latency: an operand accepted at edge T gives out_valid high from edge T+ITERS+4. With the default ITERS=16 that is 20 edges.
- The result registers persist after the DONE handshake until the next LOAD.
- Reset mid-operation (any state): immediate return to IDLE and full clear; no stop pulse is issued and no partial result is emitted.
- out_ready held at 1 while in DONE: the handshake completes in the first DONE cycle.

Test Plan:
- Reset with in_valid=1 held -> in_ready=1 and all other outputs 0. After release, an accept at edge T gives sq_start high in cycle T+1 only and sq_stop high in cycle T+18 only (ITERS=16).
- in_x=1000000, behavioural core model -> out_sqrt=1000, out_rem=0, out_exact=1, out_err=0; out_valid rises at edge T+20; op_count=1 after the handshake.
- in_x=0xFFFFFFFF -> out_sqrt=65535, out_rem=131070 (0x1FFFE), out_exact=0. Also in_x=17 -> out_sqrt=4, out_rem=1. Also in_x=0 -> out_sqrt=0, out_exact=1.
- Core model forced to return 5 for in_x=24 -> out_err=1, out_rem=0. Model forced to return 3 for in_x=24 -> out_err=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid pulses during that time are dropped.
  - Then out_ready=1 -> return to IDLE; op_count increments once.
- Assert reset during RUN (counter=7) -> busy=0 and out_valid=0 immediately; no sq_stop; op_count=0. A subsequent operand 81 -> out_sqrt=9.

Source files
------------

// File: rtl/sqrt_seq_ctrl_if.sv
// Operand, core and result signals shared between the sqrt sequencer and its neighbours.
// slave is the controller's view; master is the view of whoever drives operands and models the core.
interface sqrt_seq_ctrl_if #(
    parameter int NUMBITS = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NUMBITS-1:0]     in_x;
    logic                   sq_start;
    logic                   sq_stop;
    logic [NUMBITS-1:0]     sq_xin;
    logic [NUMBITS/2-1:0]   sq_sqrt;
    logic                   out_valid;
    logic                   out_ready;
    logic [NUMBITS/2-1:0]   out_sqrt;
    logic [NUMBITS/2:0]     out_rem;
    logic                   out_exact;
    logic                   out_err;
    logic                   busy;
    logic [15:0]            op_count;

    modport slave (
        input  in_valid, in_x, sq_sqrt, out_ready,
        output in_ready, sq_start, sq_stop, sq_xin,
               out_valid, out_sqrt, out_rem, out_exact, out_err, busy, op_count
    );

    modport master (
        output in_valid, in_x, sq_sqrt, out_ready,
        input  in_ready, sq_start, sq_stop, sq_xin,
               out_valid, out_sqrt, out_rem, out_exact, out_err, busy, op_count
    );
endinterface

// File: rtl/sqrt_seq_ctrl.sv
// Sequences one psdsqrt run per operand: start, ITERS iterations, stop, capture and check the root.
// Accept-to-out_valid is ITERS+4 edges; one operand in flight, in_ready only in IDLE, result held until out_ready.
module sqrt_seq_ctrl #(
    parameter int NUMBITS = 32,
    parameter int ITERS   = NUMBITS / 2
) (
    input  logic            clock,
    input  logic            reset,
    sqrt_seq_ctrl_if.slave  bus
);
    localparam int H  = NUMBITS / 2;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [2:0] {IDLE, START, RUN, STOP, LOAD, DONE} state_t;

    state_t             state, next_state;
    logic [CW-1:0]      iter_cnt;
    logic [NUMBITS-1:0] xin_q;
    logic [H-1:0]       sqrt_q;
    logic [H:0]         rem_q;
    logic               exact_q, err_q;
    logic [15:0]        op_count_q;

    logic [NUMBITS-1:0] root_ext, sq, diff;
    logic               over, too_small;
    logic [H:0]         rem_d;
    logic               err_d, exact_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = START;
            START:   next_state = RUN;
            RUN:     if (iter_cnt == '0) next_state = STOP;
            STOP:    next_state = LOAD;
            LOAD:    next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Root check: a valid floor root r satisfies r*r <= x <= r*r + 2r.
    always_comb begin
        root_ext  = {{(NUMBITS-H){1'b0}}, bus.sq_sqrt};
        sq        = root_ext * root_ext;
        diff      = xin_q - sq;
        over      = sq > xin_q;
        too_small = !over && (diff > {root_ext[NUMBITS-2:0], 1'b0});
        rem_d     = over ? '0 : diff[H:0];
        err_d     = over || too_small;
        exact_d   = !err_d && (diff == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iter_cnt   <= '0;
            xin_q      <= '0;
            sqrt_q     <= '0;
            rem_q      <= '0;
            exact_q    <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            case (state)
                IDLE:  if (bus.in_valid) xin_q <= bus.in_x;
                START: iter_cnt <= CW'(ITERS - 1);
                RUN:   if (iter_cnt != '0) iter_cnt <= iter_cnt - 1'b1;
                LOAD: begin
                    sqrt_q  <= bus.sq_sqrt;
                    rem_q   <= rem_d;
                    exact_q <= exact_d;
                    err_q   <= err_d;
                end
                DONE:  if (bus.out_ready) op_count_q <= op_count_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.sq_start  = (state == START);
    assign bus.sq_stop   = (state == STOP);
    assign bus.sq_xin    = xin_q;
    assign bus.out_valid = (state == DONE);
    assign bus.out_sqrt  = sqrt_q;
    assign bus.out_rem   = rem_q;
    assign bus.out_exact = exact_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_sqrt_seq_ctrl.sv
// Directed bench for sqrt_seq_ctrl with a behavioural square-root core that can be forced to a wrong root.
module tb_sqrt_seq_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        force_en  = 1'b0;
    logic [15:0] force_val = '0;

    sqrt_seq_ctrl_if #(.NUMBITS(32)) bus ();

    sqrt_seq_ctrl #(.NUMBITS(32), .ITERS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] isqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
        end
        return r;
    endfunction

    always_comb bus.sq_sqrt = force_en ? force_val : isqrt(bus.sq_xin);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents x for one accepting edge (e0), then samples #1 after each later edge.
    // Sample index n shows what the DUT presents to edge e0+n+1.
    task automatic run_op(input logic [31:0] x, output int lat, output int start_at,
                          output int stop_at, output int starts, output int stops);
        lat = -1; start_at = -1; stop_at = -1; starts = 0; stops = 0;
        bus.in_x     = x;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.sq_start) begin starts++; start_at = n; end
            if (bus.sq_stop)  begin stops++;  stop_at  = n; end
            if (bus.out_valid) begin lat = n; break; end
            tick();
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] s, input logic [16:0] r,
                                input logic e, input logic x);
        int lat, sa, so, ns, np;
        run_op(bus.in_x, lat, sa, so, ns, np);
        check({tag, "_lat"},   64'(lat), 64'd19);
        check({tag, "_sqrt"},  64'(bus.out_sqrt), 64'(s));
        check({tag, "_rem"},   64'(bus.out_rem), 64'(r));
        check({tag, "_err"},   64'(bus.out_err), 64'(e));
        check({tag, "_exact"}, 64'(bus.out_exact), 64'(x));
        tick();
    endtask

    initial begin
        int lat, sa, so, ns, np;
        logic [15:0] cnt_before;

        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'd1234;
        bus.out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_start",     64'(bus.sq_start), 64'd0);
        check("rst_stop",      64'(bus.sq_stop), 64'd0);
        check("rst_xin",       64'(bus.sq_xin), 64'd0);
        check("rst_outs",      64'({bus.out_sqrt, bus.out_rem, bus.out_exact, bus.out_err}), 64'd0);
        check("rst_count",     64'(bus.op_count), 64'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick();

        run_op(32'd1000000, lat, sa, so, ns, np);
        check("t1_start_n",  64'(ns), 64'd1);
        check("t1_start_at", 64'(sa), 64'd0);
        check("t1_stop_n",   64'(np), 64'd1);
        check("t1_stop_at",  64'(so), 64'd17);
        check("t1_lat",      64'(lat), 64'd19);
        check("t1_in_ready", 64'(bus.in_ready), 64'd0);
        check("t1_xin",      64'(bus.sq_xin), 64'd1000000);
        check("t1_sqrt",     64'(bus.out_sqrt), 64'd1000);
        check("t1_rem",      64'(bus.out_rem), 64'd0);
        check("t1_exact",    64'(bus.out_exact), 64'd1);
        check("t1_err",      64'(bus.out_err), 64'd0);
        tick();
        check("t1_count",    64'(bus.op_count), 64'd1);
        check("t1_idle",     64'(bus.busy), 64'd0);
        check("t1_persist",  64'(bus.out_sqrt), 64'd1000);

        bus.in_x = 32'hFFFF_FFFF; check_result("max", 16'd65535, 17'h1FFFE, 1'b0, 1'b0);
        bus.in_x = 32'd17;        check_result("x17", 16'd4, 17'd1, 1'b0, 1'b0);
        bus.in_x = 32'd0;         check_result("zero", 16'd0, 17'd0, 1'b0, 1'b1);
        force_en = 1'b1;
        force_val = 16'd5; bus.in_x = 32'd24; check_result("big_root", 16'd5, 17'd0, 1'b1, 1'b0);
        force_val = 16'd3; bus.in_x = 32'd24; check_result("small_root", 16'd3, 17'd15, 1'b1, 1'b0);
        force_en = 1'b0;
        check("count6", 64'(bus.op_count), 64'd6);

        bus.out_ready = 1'b0;
        run_op(32'd100, lat, sa, so, ns, np);
        check("bp_lat", 64'(lat), 64'd19);
        cnt_before = bus.op_count;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_x     = 32'd5;
            tick();
            check("bp_valid",    64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold",     64'({bus.out_sqrt, bus.out_rem, bus.out_err, bus.out_exact}),
                                 64'({16'd10, 17'd0, 1'b0, 1'b1}));
            check("bp_xin",      64'(bus.sq_xin), 64'd100);
        end
        check("bp_count_held", 64'(bus.op_count), 64'(cnt_before));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle",  64'(bus.busy), 64'd0);
        check("bp_count", 64'(bus.op_count), 64'd7);
        tick();
        check("bp_dropped", 64'(bus.busy), 64'd0);

        bus.in_x     = 32'd50;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy",  64'(bus.busy), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_count", 64'(bus.op_count), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        tick();
        reset = 1'b0;
        np = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.sq_stop || bus.out_valid || bus.busy) np++;
            tick();
        end
        check("mid_no_activity", 64'(np), 64'd0);
        run_op(32'd81, lat, sa, so, ns, np);
        check("post_lat",  64'(lat), 64'd19);
        check("post_sqrt", 64'(bus.out_sqrt), 64'd9);
        check("post_rem",  64'(bus.out_rem), 64'd0);
        tick();
        check("post_count", 64'(bus.op_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
